// File: rtl/acq_peak_search_pkg.sv
// Shared acquisition definitions: search FSM states, grid geometry, datapath widths.
// The top level takes its parameter defaults from here.
package acq_peak_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_DEC1   = 3'd2,
        ST_DEC2   = 3'd3,
        ST_DONE   = 3'd4
    } acq_state_t;

    localparam int NUM_BINS   = 3;
    localparam int NUM_SHIFTS = 2046;
    localparam int I2Q2_WIDTH = 32;
    localparam int CS_WIDTH   = 11;
    localparam int BIN_WIDTH  = 2;
    localparam int THRESH     = 4;

    // Width of a sum of `cells` values of width `vw`; it cannot overflow.
    function automatic int sum_width(input int vw, input int cells);
        return vw + $clog2(cells);
    endfunction

    localparam int SUM_W = sum_width(I2Q2_WIDTH, NUM_BINS * NUM_SHIFTS);

endpackage

// File: rtl/acq_peak_search_threshold_cmp.sv
// Two-stage detection test: register peak*cells and noise_sum*THRESH, then compare.
// Comparing peak*cells against sum*THRESH avoids a divide for the mean.
module acq_threshold_cmp #(
    parameter int VAL_W  = 32,
    parameter int SUM_W  = 36,
    parameter int CELLS  = 6138,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             compare,
    input  logic [VAL_W-1:0] peak_value,
    input  logic [SUM_W-1:0] noise_sum,
    output logic             detected
);

    localparam int PROD_W = SUM_W + $clog2(THRESH) + 1;

    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            lhs      <= '0;
            rhs      <= '0;
            detected <= 1'b0;
        end else begin
            if (load) begin
                lhs <= PROD_W'(peak_value) * PROD_W'(CELLS);
                rhs <= PROD_W'(noise_sum) * PROD_W'(THRESH);
            end
            if (compare) begin
                detected <= (lhs > rhs);
            end
        end
    end

endmodule

// File: rtl/acq_peak_search.sv
// Peak search over the code-shift x Doppler grid with a noise-floor ratio detector.
// valid/ready: there is no ready; a value is taken whenever i2q2_valid=1 in SEARCH with the expected tag.
module acq_peak_search
    import acq_peak_search_pkg::*;
#(
    parameter int NUM_BINS   = acq_peak_search_pkg::NUM_BINS,
    parameter int NUM_SHIFTS = acq_peak_search_pkg::NUM_SHIFTS,
    parameter int I2Q2_WIDTH = acq_peak_search_pkg::I2Q2_WIDTH,
    parameter int CS_WIDTH   = acq_peak_search_pkg::CS_WIDTH,
    parameter int BIN_WIDTH  = acq_peak_search_pkg::BIN_WIDTH,
    parameter int THRESH     = acq_peak_search_pkg::THRESH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  i2q2_valid,
    input  logic [I2Q2_WIDTH-1:0] i2q2_value,
    input  logic [BIN_WIDTH-1:0]  i2q2_tag,
    input  logic [CS_WIDTH-1:0]   code_shift,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  detected,
    output logic [BIN_WIDTH-1:0]  peak_bin,
    output logic [CS_WIDTH-1:0]   peak_code_shift,
    output logic [I2Q2_WIDTH-1:0] peak_value,
    output logic [sum_width(I2Q2_WIDTH, NUM_BINS*NUM_SHIFTS)-1:0] noise_sum,
    output logic                  seq_error,
    output acq_state_t            state_dbg
);

    localparam int CELLS = NUM_BINS * NUM_SHIFTS;
    localparam int SUM_W = sum_width(I2Q2_WIDTH, CELLS);
    localparam int CNT_W = (NUM_SHIFTS > 1) ? $clog2(NUM_SHIFTS) : 1;

    acq_state_t           state;
    acq_state_t           state_next;
    logic [BIN_WIDTH-1:0] expected_tag;
    logic [CNT_W-1:0]     shift_count;

    logic search_valid;
    logic accept;
    logic last_bin;
    logic first_cell;
    logic sweep_end;

    // start wins over a coincident valid, so it also masks acceptance.
    assign search_valid = (state == ST_SEARCH) && i2q2_valid && !start;
    assign accept       = search_valid && (i2q2_tag == expected_tag);
    assign last_bin     = (expected_tag == BIN_WIDTH'(NUM_BINS - 1));
    assign first_cell   = (expected_tag == '0) && (shift_count == '0);
    assign sweep_end    = accept && last_bin && (shift_count == CNT_W'(NUM_SHIFTS - 1));

    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = ST_IDLE;
            ST_SEARCH: if (sweep_end) state_next = ST_DEC1;
            ST_DEC1:   state_next = ST_DEC2;
            ST_DEC2:   state_next = ST_DONE;
            ST_DONE:   state_next = ST_DONE;
            default:   state_next = ST_IDLE;
        endcase
        if (start) begin
            state_next = ST_SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || start) begin
            expected_tag    <= '0;
            shift_count     <= '0;
            peak_value      <= '0;
            peak_bin        <= '0;
            peak_code_shift <= '0;
            noise_sum       <= '0;
            seq_error       <= 1'b0;
            result_valid    <= 1'b0;
        end else begin
            if (accept) begin
                noise_sum <= noise_sum + SUM_W'(i2q2_value);
                // The first cell always loads, so an all-zero sweep still reports its first shift.
                if (first_cell || (i2q2_value > peak_value)) begin
                    peak_value      <= i2q2_value;
                    peak_bin        <= i2q2_tag;
                    peak_code_shift <= code_shift;
                end
                if (last_bin) begin
                    expected_tag <= '0;
                    shift_count  <= shift_count + 1'b1;
                end else begin
                    expected_tag <= expected_tag + 1'b1;
                end
            end else if (search_valid) begin
                seq_error <= 1'b1;
            end
            if (state == ST_DEC2) begin
                result_valid <= 1'b1;
            end
        end
    end

    acq_threshold_cmp #(
        .VAL_W  (I2Q2_WIDTH),
        .SUM_W  (SUM_W),
        .CELLS  (CELLS),
        .THRESH (THRESH)
    ) u_threshold_cmp (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start),
        .load       (state == ST_DEC1),
        .compare    (state == ST_DEC2),
        .peak_value (peak_value),
        .noise_sum  (noise_sum),
        .detected   (detected)
    );

endmodule

// File: doc/acq_peak_search.md
Name: acq_peak_search

Overview:
- Downstream of the acquisition unit; consumes its tagged I^2+Q^2 stream (one value per Doppler bin per code shift).
- Tracks the global maximum over the full code-shift × Doppler search grid and accumulates the grid energy for a noise-floor estimate.
- At sweep end, issues a detect/no-detect decision with the peak's Doppler bin and code shift.
- Feeds the channel hand-off logic that seeds tracking.

Parameters:
- NUM_BINS, 3, Doppler bins per code shift (tags 0..NUM_BINS-1)
- NUM_SHIFTS, 2046, code shifts per sweep (half-chip steps over 1023 chips)
- I2Q2_WIDTH, 32, width of the incoming I^2+Q^2 value
- CS_WIDTH, 11, code-shift width
- BIN_WIDTH, 2, tag/bin index width
- THRESH, 4, detection ratio: peak must exceed THRESH × mean cell energy

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; clears state and begins a sweep
- i2q2_valid  in  1  input value valid this cycle
- i2q2_value  in  I2Q2_WIDTH  unsigned I^2+Q^2
- i2q2_tag  in  BIN_WIDTH  Doppler bin of value
- code_shift  in  CS_WIDTH  code shift the value belongs to; sampled with valid
- busy  out  1  sweep or decision in progress
- result_valid  out  1  results stable; held until next start or reset
- detected  out  1  peak passed threshold test
- peak_bin  out  BIN_WIDTH  bin of peak
- peak_code_shift  out  CS_WIDTH  code shift of peak
- peak_value  out  I2Q2_WIDTH  peak energy
- noise_sum  out  SUM_W  sum of all accepted values; SUM_W = I2Q2_WIDTH + clog2(NUM_BINS*NUM_SHIFTS)
- seq_error  out  1  sticky; out-of-order tag seen this sweep

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; all outputs 0; internal counters 0. Reset has priority over all other inputs, including mid-sweep.
- States:
  - IDLE: start -> SEARCH.
  - SEARCH: last value accepted -> DEC1.
  - DEC1 -> DEC2 -> DONE.
  - DONE: start -> SEARCH.
  - start in any non-IDLE state aborts and restarts: same clearing as from IDLE.
- On start: peak_value/bin/shift, noise_sum, expected tag, shift counter, seq_error, result_valid, detected all cleared; busy=1 from the next cycle. busy=0 only in IDLE and DONE.
- Acceptance (SEARCH only):
  - A value is accepted when i2q2_valid=1 and i2q2_tag == expected_tag.
  - Mismatched tag: value dropped, seq_error<=1, expected_tag unchanged.
  - Valids outside SEARCH are ignored, with no error.
- Per accepted value:
  - noise_sum += value.
  - If value > peak_value (strictly), latch value, tag and code_shift. Ties keep the earliest cell; an all-zero sweep reports bin 0, the first code shift, peak 0.
  - expected_tag wraps NUM_BINS-1 -> 0 and increments shift_count.
- Sweep end: accepting tag NUM_BINS-1 when shift_count == NUM_SHIFTS-1 -> DEC1. Any valid in that same cycle beyond it is ignored.
- DEC1: register lhs = peak_value × (NUM_BINS*NUM_SHIFTS) and rhs = noise_sum × THRESH. Widths are SUM_W + clog2(THRESH) + 1; no overflow is permitted.
- DEC2: detected <= (lhs > rhs).
- DONE: result_valid=1 from the cycle after DEC2. Latency from final accepted valid to result_valid is 3 clocks.
- Results stay constant in DONE; start clears them in the same edge that enters SEARCH.
- Simultaneous start and valid: start wins; the valid is not accepted.

Decomposition:
- Shared acquisition package holds:
  - state enum (IDLE, SEARCH, DEC1, DEC2, DONE)
  - grid-size constants NUM_BINS, NUM_SHIFTS
  - I2Q2/CS/bin widths
  - clog2-derived SUM_W
- One natural sub-module: acq_threshold_cmp, the two-stage registered multiply-and-compare for DEC1/DEC2.

Test Plan:
- NUM_BINS=3, NUM_SHIFTS=4, all values 10, one cell (bin 2, shift 7) = 500 -> peak_value=500, peak_bin=2, peak_code_shift=7, noise_sum=610, detected=1 (500×12=6000 > 610×4=2440), result_valid exactly 3 clocks after last valid.
- Flat grid of all 100 -> peak at first cell (bin 0, first shift, ties not replaced), noise_sum=1200, detected=0 (1200 vs 4800).
- Tag sequence 0,2,1,2 on first shift -> tag 2 dropped, seq_error=1 sticky, remaining values accepted; sweep completes after 12 accepted values.
- start asserted mid-sweep after 5 values -> all outputs cleared, busy stays 1, new sweep needs a full 12 values before result_valid.
- reset_n low during DEC1 -> next cycle IDLE, all outputs 0; valids ignored until start.
- start coincident with i2q2_valid in DONE -> results cleared, that value not counted (noise_sum=0 next cycle).
